// File: rtl/mdch.sv
// mdch: parametrised multi-digit up/down counter.
//   DIGITS cascaded modulo-MOD digits, each DIG_W bits wide, with a ripple
//   carry/borrow enable chain. Supports sync clear, parallel load with
//   out-of-range clamping, wrap or saturate at the limits, a terminal-count
//   pulse and a sticky overflow flag. BCD by default.
// Ports:
//   mdch_clk, mdch_rst_n        clock, async active-low reset
//   mdch_en/up/sat              step enable, direction, saturate mode
//   mdch_clr, mdch_ld           sync clear (highest priority), parallel load
//   mdch_ld_val                 load value, digit i at [i*DIG_W +: DIG_W]
//   mdch_out                    count, digit 0 least significant
//   mdch_tc                     pulse: the step hit a limit
//   mdch_ovf                    sticky limit flag, cleared by clr/reset
//   mdch_ld_err                 pulse: last load had a digit >= MOD
//   mdch_zero                   all digits zero

// Per-digit combinational slice: step candidates, limit detects, load clamp.
module mdch_digit #(
    parameter int DIG_W = 4,
    parameter int MOD   = 10
) (
    input  logic [DIG_W-1:0] d,
    input  logic [DIG_W-1:0] ld_d,
    output logic [DIG_W-1:0] inc,
    output logic [DIG_W-1:0] dec,
    output logic [DIG_W-1:0] ld_fix,
    output logic             is_max,
    output logic             is_zero,
    output logic             ld_bad
);
    localparam logic [DIG_W-1:0] MAXD = DIG_W'(MOD - 1);

    assign is_max  = (d == MAXD);
    assign is_zero = (d == '0);
    // Explicit roll-over keeps the digit inside 0..MOD-1 even when MOD < 2**DIG_W.
    assign inc     = is_max  ? '0   : d + DIG_W'(1);
    assign dec     = is_zero ? MAXD : d - DIG_W'(1);
    // Widen before comparing so MOD == 2**DIG_W never flags.
    assign ld_bad  = (int'(ld_d) >= MOD);
    assign ld_fix  = ld_bad ? MAXD : ld_d;
endmodule

module mdch #(
    parameter int DIGITS = 4,
    parameter int DIG_W  = 4,
    parameter int MOD    = 10
) (
    input  logic                    mdch_clk,
    input  logic                    mdch_rst_n,
    input  logic                    mdch_en,
    input  logic                    mdch_up,
    input  logic                    mdch_sat,
    input  logic                    mdch_clr,
    input  logic                    mdch_ld,
    input  logic [DIGITS*DIG_W-1:0] mdch_ld_val,
    output logic [DIGITS*DIG_W-1:0] mdch_out,
    output logic                    mdch_tc,
    output logic                    mdch_ovf,
    output logic                    mdch_ld_err,
    output logic                    mdch_zero
);
    logic [DIGITS-1:0][DIG_W-1:0] cnt, nxt, inc, dec, ldv, ldf;
    logic [DIGITS-1:0]            is_max, is_zero, ld_bad;
    // pmax[i] / pzero[i]: all digits below i are at MOD-1 / 0.
    logic [DIGITS:0]              pmax, pzero;
    logic                         limit;

    assign ldv      = mdch_ld_val;
    assign pmax[0]  = 1'b1;
    assign pzero[0] = 1'b1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        mdch_digit #(.DIG_W(DIG_W), .MOD(MOD)) u_dig (
            .d      (cnt[g]),
            .ld_d   (ldv[g]),
            .inc    (inc[g]),
            .dec    (dec[g]),
            .ld_fix (ldf[g]),
            .is_max (is_max[g]),
            .is_zero(is_zero[g]),
            .ld_bad (ld_bad[g])
        );
        assign pmax[g+1]  = pmax[g]  & is_max[g];
        assign pzero[g+1] = pzero[g] & is_zero[g];
    end

    // Whole-counter limit for the requested direction. In wrap mode the
    // normal digit roll-over already yields all-0 / all-(MOD-1).
    assign limit = mdch_up ? pmax[DIGITS] : pzero[DIGITS];

    always_comb begin
        nxt = cnt;
        for (int i = 0; i < DIGITS; i++) begin
            if (mdch_up) begin
                if (pmax[i])  nxt[i] = inc[i];
            end else begin
                if (pzero[i]) nxt[i] = dec[i];
            end
        end
    end

    always_ff @(posedge mdch_clk or negedge mdch_rst_n) begin
        if (!mdch_rst_n) begin
            cnt         <= '0;
            mdch_tc     <= 1'b0;
            mdch_ovf    <= 1'b0;
            mdch_ld_err <= 1'b0;
        end else if (mdch_clr) begin
            cnt         <= '0;
            mdch_tc     <= 1'b0;
            mdch_ovf    <= 1'b0;
            mdch_ld_err <= 1'b0;
        end else if (mdch_ld) begin
            cnt         <= ldf;
            mdch_tc     <= 1'b0;
            mdch_ld_err <= |ld_bad;
        end else begin
            mdch_ld_err <= 1'b0;
            mdch_tc     <= mdch_en & limit;
            if (mdch_en) begin
                if (limit)               mdch_ovf <= 1'b1;
                if (!(limit && mdch_sat)) cnt     <= nxt;
            end
        end
    end

    assign mdch_out  = cnt;
    assign mdch_zero = ~|cnt;
endmodule

// File: tb/tb_mdch.sv
module tb_mdch;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // default BCD instance
    logic        rst_n, en, up, sat, clr, ld;
    logic [15:0] ld_val, out;
    logic        tc, ovf, ld_err, zero;

    // octal instance (DIGITS=2 DIG_W=3 MOD=8)
    logic        o_rst_n, o_en, o_up, o_sat, o_clr, o_ld;
    logic [5:0]  o_ld_val, o_out;
    logic        o_tc, o_ovf, o_ld_err, o_zero;

    int checks = 0, failures = 0;

    // reference model state: counter value as a plain integer 0..9999
    int m_val;
    bit m_tc, m_ovf, m_lderr;

    mdch u_dut (
        .mdch_clk(clk), .mdch_rst_n(rst_n), .mdch_en(en), .mdch_up(up),
        .mdch_sat(sat), .mdch_clr(clr), .mdch_ld(ld), .mdch_ld_val(ld_val),
        .mdch_out(out), .mdch_tc(tc), .mdch_ovf(ovf), .mdch_ld_err(ld_err),
        .mdch_zero(zero)
    );

    mdch #(.DIGITS(2), .DIG_W(3), .MOD(8)) u_oct (
        .mdch_clk(clk), .mdch_rst_n(o_rst_n), .mdch_en(o_en), .mdch_up(o_up),
        .mdch_sat(o_sat), .mdch_clr(o_clr), .mdch_ld(o_ld), .mdch_ld_val(o_ld_val),
        .mdch_out(o_out), .mdch_tc(o_tc), .mdch_ovf(o_ovf), .mdch_ld_err(o_ld_err),
        .mdch_zero(o_zero)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int x;
        x = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic model(input bit c, input bit l, input logic [15:0] lv,
                         input bit e, input bit u, input bit s);
        if (c) begin
            m_val = 0; m_ovf = 0; m_tc = 0; m_lderr = 0;
        end else if (l) begin
            int d, p;
            m_val = 0; m_lderr = 0; m_tc = 0; p = 1;
            for (int i = 0; i < 4; i++) begin
                d = int'(lv[4*i +: 4]);
                if (d >= 10) begin d = 9; m_lderr = 1; end
                m_val += d * p;
                p *= 10;
            end
        end else begin
            m_lderr = 0; m_tc = 0;
            if (e) begin
                if (u && m_val == 9999) begin
                    m_tc = 1; m_ovf = 1; if (!s) m_val = 0;
                end else if (!u && m_val == 0) begin
                    m_tc = 1; m_ovf = 1; if (!s) m_val = 9999;
                end else begin
                    m_val += u ? 1 : -1;
                end
            end
        end
    endtask

    task automatic step(input bit c, input bit l, input logic [15:0] lv,
                        input bit e, input bit u, input bit s);
        clr = c; ld = l; ld_val = lv; en = e; up = u; sat = s;
        @(posedge clk);
        #1;
        model(c, l, lv, e, u, s);
        chk("out",    32'(out),    32'(to_bcd(m_val)));
        chk("tc",     32'(tc),     32'(m_tc));
        chk("ovf",    32'(ovf),    32'(m_ovf));
        chk("ld_err", 32'(ld_err), 32'(m_lderr));
        chk("zero",   32'(zero),   32'(m_val == 0));
    endtask

    initial begin
        rst_n = 0; en = 0; up = 1; sat = 0; clr = 0; ld = 0; ld_val = '0;
        o_rst_n = 0; o_en = 0; o_up = 1; o_sat = 0; o_clr = 0; o_ld = 0; o_ld_val = '0;
        m_val = 0; m_tc = 0; m_ovf = 0; m_lderr = 0;
        #2;
        chk("rst_out",    32'(out),    32'h0);
        chk("rst_tc",     32'(tc),     32'h0);
        chk("rst_ovf",    32'(ovf),    32'h0);
        chk("rst_ld_err", 32'(ld_err), 32'h0);
        chk("rst_zero",   32'(zero),   32'h1);
        #1;
        rst_n = 1; o_rst_n = 1;

        // full up walk 0000..9999 and wrap
        for (int k = 0; k < 10000; k++) step(0, 0, '0, 1, 1, 0);
        chk("t1_wrap_out", 32'(out), 32'h0000);
        chk("t1_wrap_tc",  32'(tc),  32'h1);
        chk("t1_ovf",      32'(ovf), 32'h1);

        // carry across digits, borrow wrap from zero
        step(1, 0, '0, 0, 1, 0);
        step(0, 1, 16'h0199, 0, 1, 0);
        step(0, 0, '0, 1, 1, 0);
        chk("t2_carry", 32'(out), 32'h0200);
        step(0, 1, 16'h0000, 0, 0, 0);
        step(0, 0, '0, 1, 0, 0);
        chk("t2_borrow", 32'(out), 32'h9999);
        chk("t2_tc",     32'(tc),  32'h1);

        // saturate at top, then step down
        step(0, 1, 16'h9999, 0, 1, 1);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, '0, 1, 1, 1);
            chk("t3_sat_out", 32'(out), 32'h9999);
            chk("t3_sat_tc",  32'(tc),  32'h1);
        end
        step(0, 0, '0, 1, 0, 1);
        chk("t3_down", 32'(out), 32'h9998);
        chk("t3_tc0",  32'(tc),  32'h0);

        // out-of-range load is clamped, en ignored that cycle
        step(0, 1, 16'h1A3F, 1, 1, 0);
        chk("t4_out",    32'(out),    32'h1939);
        chk("t4_ld_err", 32'(ld_err), 32'h1);
        step(0, 0, '0, 0, 1, 0);
        chk("t4_ld_err_drop", 32'(ld_err), 32'h0);

        // clr wins over ld and en
        step(0, 1, 16'h0000, 0, 0, 1);
        step(0, 0, '0, 1, 0, 1);
        chk("t5_pre_ovf", 32'(ovf), 32'h1);
        step(1, 1, 16'hFFFF, 1, 1, 0);
        chk("t5_out", 32'(out), 32'h0);
        chk("t5_ovf", 32'(ovf), 32'h0);

        // randomized mix against the model
        for (int k = 0; k < 3000; k++) begin
            int r;
            logic [15:0] lv;
            r  = int'($urandom_range(0, 99));
            lv = 16'($urandom);
            if (r < 5)       lv = 16'h9998;
            else if (r < 8)  lv = 16'h0001;
            step(r >= 97, (r < 12) && (r != 0), lv,
                 $urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom_range(0, 3) == 0));
        end

        // octal instance: async reset mid-count, then a full 00..77 lap
        o_en = 1;
        for (int k = 0; k < 5; k++) begin @(posedge clk); #1; end
        chk("t6_pre", 32'(o_out), 32'd5);
        o_rst_n = 0;
        #1;
        chk("t6_async_out", 32'(o_out), 32'h0);
        chk("t6_async_ovf", 32'(o_ovf), 32'h0);
        #1;
        o_rst_n = 1;
        for (int k = 1; k <= 64; k++) begin
            @(posedge clk); #1;
            chk("t6_out", 32'(o_out), 32'(k % 64));
            chk("t6_tc",  32'(o_tc),  32'(k == 64));
        end
        chk("t6_ovf",    32'(o_ovf),    32'h1);
        chk("t6_ld_err", 32'(o_ld_err), 32'h0);
        chk("t6_zero",   32'(o_zero),   32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
